// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the line memory bus, with downstream
// id re-tagging through a 4-entry outstanding table and response steering.
package Mem;
  typedef logic [27:0] lineaddr_t;
  typedef logic [63:0] line_t;
endpackage

module mem_bus_arbiter (
  input  logic          clk,
  input  logic          rst,
  // requester 0 (L1 instruction cache)
  input  logic          r0_req_valid,
  output logic          r0_req_ready,
  input  logic [1:0]    r0_req_id,
  input  logic          r0_req_we,
  input  Mem::lineaddr_t r0_req_addr,
  input  Mem::line_t    r0_req_data,
  output logic          r0_resp_valid,
  input  logic          r0_resp_ready,
  output logic [1:0]    r0_resp_id,
  output Mem::line_t    r0_resp_data,
  // requester 1 (L1 data cache)
  input  logic          r1_req_valid,
  output logic          r1_req_ready,
  input  logic [1:0]    r1_req_id,
  input  logic          r1_req_we,
  input  Mem::lineaddr_t r1_req_addr,
  input  Mem::line_t    r1_req_data,
  output logic          r1_resp_valid,
  input  logic          r1_resp_ready,
  output logic [1:0]    r1_resp_id,
  output Mem::line_t    r1_resp_data,
  // downstream memory bus
  output logic          req_valid,
  output logic          req_we,
  output logic [1:0]    req_id,
  output Mem::lineaddr_t req_addr,
  output Mem::line_t    req_data,
  input  logic          req_ready,
  input  logic          resp_valid,
  input  logic [1:0]    resp_id,
  input  Mem::line_t    resp_data,
  output logic          resp_ready,
  // status
  output logic [2:0]    outstanding,
  output logic          stray_resp
);

  logic [3:0] tag_valid_r;
  logic [3:0] tag_src_r;
  logic [1:0] tag_uid_r [4];
  logic       last_r;
  logic       lock_r;
  logic       lock_grant_r;
  logic [1:0] lock_tag_r;
  logic       stray_r;

  logic       free_s;
  logic [1:0] cand_s;
  logic       grant_s;
  logic [1:0] tag_s;
  logic       sel_valid_s;
  logic       req_hs_s;
  logic       resp_hit_s;
  logic       resp_src_s;
  logic       resp_hs_s;

  function automatic logic [1:0] lowest_free(input logic [3:0] v);
    if (!v[0]) begin
      return 2'd0;
    end else if (!v[1]) begin
      return 2'd1;
    end else if (!v[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  function automatic logic [2:0] count_ones(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Grant and tag selection; a stalled offer stays pinned to its source and tag.
  always_comb begin
    free_s  = ~&tag_valid_r;
    cand_s  = lowest_free(tag_valid_r);
    grant_s = 1'b0;
    tag_s   = cand_s;
    if (lock_r) begin
      grant_s = lock_grant_r;
      tag_s   = lock_tag_r;
    end else begin
      tag_s = cand_s;
      case ({r1_req_valid, r0_req_valid})
        2'b11:   grant_s = ~last_r;
        2'b10:   grant_s = 1'b1;
        default: grant_s = 1'b0;
      endcase
    end
    sel_valid_s = grant_s ? r1_req_valid : r0_req_valid;
  end

  // Downstream request mux and upstream ready.
  always_comb begin
    req_valid    = ~rst & sel_valid_s & free_s;
    req_id       = tag_s;
    req_we       = grant_s ? r1_req_we   : r0_req_we;
    req_addr     = grant_s ? r1_req_addr : r0_req_addr;
    req_data     = grant_s ? r1_req_data : r0_req_data;
    r0_req_ready = ~rst & ~grant_s & free_s & req_ready;
    r1_req_ready = ~rst &  grant_s & free_s & req_ready;
    req_hs_s     = req_valid & req_ready;
  end

  // Response steering; a response for an unallocated tag is swallowed.
  always_comb begin
    resp_hit_s    = tag_valid_r[resp_id];
    resp_src_s    = tag_src_r[resp_id];
    r0_resp_valid = ~rst & resp_valid & resp_hit_s & ~resp_src_s;
    r1_resp_valid = ~rst & resp_valid & resp_hit_s &  resp_src_s;
    r0_resp_id    = tag_uid_r[resp_id];
    r1_resp_id    = tag_uid_r[resp_id];
    r0_resp_data  = resp_data;
    r1_resp_data  = resp_data;
    if (rst) begin
      resp_ready = 1'b0;
    end else if (resp_hit_s) begin
      resp_ready = resp_src_s ? r1_resp_ready : r0_resp_ready;
    end else begin
      resp_ready = 1'b1;
    end
    resp_hs_s = resp_valid & resp_ready;
  end

  // Tag table, round-robin history, stall lock and stray flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_r  <= 4'b0000;
      tag_src_r    <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        tag_uid_r[i] <= 2'b00;
      end
      last_r       <= 1'b1;
      lock_r       <= 1'b0;
      lock_grant_r <= 1'b0;
      lock_tag_r   <= 2'b00;
      stray_r      <= 1'b0;
    end else begin
      // The freed entry is always valid and the allocated one invalid, so they never collide.
      if (resp_hs_s && resp_hit_s) begin
        tag_valid_r[resp_id] <= 1'b0;
      end
      if (resp_hs_s && !resp_hit_s) begin
        stray_r <= 1'b1;
      end
      if (req_hs_s) begin
        tag_valid_r[tag_s] <= 1'b1;
        tag_src_r[tag_s]   <= grant_s;
        tag_uid_r[tag_s]   <= grant_s ? r1_req_id : r0_req_id;
        last_r             <= grant_s;
      end
      lock_r       <= req_valid & ~req_ready;
      lock_grant_r <= grant_s;
      lock_tag_r   <= tag_s;
    end
  end

  assign outstanding = rst ? 3'd0 : count_ones(tag_valid_r);
  assign stray_resp  = stray_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a hand-derived vector table, corner sequences,
// then randomized traffic checked against a tag-map reference model.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic r0_req_valid, r0_req_ready, r0_req_we, r0_resp_valid, r0_resp_ready;
  logic r1_req_valid, r1_req_ready, r1_req_we, r1_resp_valid, r1_resp_ready;
  logic [1:0] r0_req_id, r1_req_id, r0_resp_id, r1_resp_id;
  Mem::lineaddr_t r0_req_addr, r1_req_addr, req_addr;
  Mem::line_t r0_req_data, r1_req_data, r0_resp_data, r1_resp_data, req_data, resp_data;
  logic req_valid, req_we, req_ready, resp_valid, resp_ready, stray_resp;
  logic [1:0] req_id, resp_id;
  logic [2:0] outstanding;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_id(r0_req_id),
    .r0_req_we(r0_req_we), .r0_req_addr(r0_req_addr), .r0_req_data(r0_req_data),
    .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready), .r0_resp_id(r0_resp_id),
    .r0_resp_data(r0_resp_data),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_id(r1_req_id),
    .r1_req_we(r1_req_we), .r1_req_addr(r1_req_addr), .r1_req_data(r1_req_data),
    .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready), .r1_resp_id(r1_resp_id),
    .r1_resp_data(r1_resp_data),
    .req_valid(req_valid), .req_we(req_we), .req_id(req_id), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_ready(resp_ready),
    .outstanding(outstanding), .stray_resp(stray_resp)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic r0v, r1v, rdy, rspv;
    logic [1:0] rspid;
    logic r0rr, r1rr;
    logic e_rv;
    logic [1:0] e_rid;
    logic e_r0rdy, e_r1rdy;
    logic [2:0] e_out;
    logic e_rsprdy, e_r0rspv, e_r1rspv;
    logic [1:0] e_uid;
  } vec_t;

  vec_t vecs [12];

  // reference model state
  int  m_src [int];
  int  m_uid [int];
  bit  m_last, m_pend, m_pend_src, m_stray;
  int  m_pend_tag;
  logic hv [2];
  logic [1:0] hid [2];
  logic hwe [2];
  Mem::lineaddr_t haddr [2];
  Mem::line_t hdata [2];
  bit acc_prev [2];
  bit rsp_v, rsp_hs_prev;

  task automatic idle_inputs();
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    r0_req_id = 2'd2; r1_req_id = 2'd1;
    r0_req_we = 1'b0; r1_req_we = 1'b1;
    r0_req_addr = 28'h0000123; r1_req_addr = 28'h0000456;
    r0_req_data = 64'h0; r1_req_data = 64'hdead_beef_0000_0001;
    r0_resp_ready = 1'b1; r1_resp_ready = 1'b1;
    req_ready = 1'b1; resp_valid = 1'b0; resp_id = 2'd0; resp_data = 64'h5a5a_0000_1111_2222;
  endtask

  task automatic model_reset();
    m_src.delete(); m_uid.delete();
    m_last = 1'b1; m_pend = 1'b0; m_pend_src = 1'b0; m_pend_tag = 0; m_stray = 1'b0;
    for (int n = 0; n < 2; n++) begin
      hv[n] = 1'b0; acc_prev[n] = 1'b0;
    end
    rsp_v = 1'b0; rsp_hs_prev = 1'b0;
  endtask

  task automatic step_rand();
    bit is_free, sel, e_rv, hit, owner, e_rsprdy;
    bit e_rdy [2];
    bit e_rspv [2];
    bit rr [2];
    int tag, t;
    @(posedge clk); #1;
    for (int n = 0; n < 2; n++) begin
      if (!(hv[n] && !acc_prev[n])) begin
        hv[n]    = ($urandom_range(0, 99) < 60);
        hid[n]   = 2'($urandom_range(0, 3));
        hwe[n]   = 1'($urandom_range(0, 1));
        haddr[n] = 28'($urandom);
        hdata[n] = {$urandom, $urandom};
      end
    end
    r0_req_valid = hv[0]; r0_req_id = hid[0]; r0_req_we = hwe[0]; r0_req_addr = haddr[0]; r0_req_data = hdata[0];
    r1_req_valid = hv[1]; r1_req_id = hid[1]; r1_req_we = hwe[1]; r1_req_addr = haddr[1]; r1_req_data = hdata[1];
    req_ready = ($urandom_range(0, 99) < 70);
    rr[0] = ($urandom_range(0, 99) < 75);
    rr[1] = ($urandom_range(0, 99) < 75);
    r0_resp_ready = rr[0]; r1_resp_ready = rr[1];
    if (!(rsp_v && !rsp_hs_prev)) begin
      t = $urandom_range(0, 3);
      if (m_src.exists(t)) rsp_v = ($urandom_range(0, 99) < 60);
      else rsp_v = ($urandom_range(0, 99) < 8);
      resp_id = 2'(t);
      resp_data = {$urandom, $urandom};
    end
    resp_valid = rsp_v;

    // expectations from the rules: lowest free tag, alternate on ties, hold a stalled offer
    is_free = (m_src.num() < 4);
    tag = 0;
    while (tag < 3 && m_src.exists(tag)) tag++;
    if (m_pend) begin
      sel = m_pend_src; tag = m_pend_tag;
    end else if (hv[0] && hv[1]) sel = !m_last;
    else sel = hv[1];
    e_rv = hv[sel] && is_free;
    e_rdy[0] = (sel == 1'b0) && is_free && req_ready;
    e_rdy[1] = (sel == 1'b1) && is_free && req_ready;
    hit = m_src.exists(int'(resp_id));
    owner = hit ? m_src[int'(resp_id)][0] : 1'b0;
    e_rsprdy = hit ? rr[owner] : 1'b1;
    e_rspv[0] = rsp_v && hit && !owner;
    e_rspv[1] = rsp_v && hit && owner;

    @(negedge clk);
    chk("rnd_req_valid", req_valid, e_rv);
    if (e_rv) begin
      chk("rnd_req_id", req_id, tag);
      chk("rnd_req_we", req_we, hwe[sel]);
      chk("rnd_req_addr", req_addr, haddr[sel]);
      chk("rnd_req_data", req_data, hdata[sel]);
    end
    chk("rnd_r0_req_ready", r0_req_ready, e_rdy[0]);
    chk("rnd_r1_req_ready", r1_req_ready, e_rdy[1]);
    chk("rnd_resp_ready", resp_ready, e_rsprdy);
    chk("rnd_r0_resp_valid", r0_resp_valid, e_rspv[0]);
    chk("rnd_r1_resp_valid", r1_resp_valid, e_rspv[1]);
    if (e_rspv[0]) begin
      chk("rnd_r0_resp_id", r0_resp_id, m_uid[int'(resp_id)]);
      chk("rnd_r0_resp_data", r0_resp_data, resp_data);
    end
    if (e_rspv[1]) begin
      chk("rnd_r1_resp_id", r1_resp_id, m_uid[int'(resp_id)]);
      chk("rnd_r1_resp_data", r1_resp_data, resp_data);
    end
    chk("rnd_outstanding", outstanding, m_src.num());
    chk("rnd_stray", stray_resp, m_stray);

    acc_prev[0] = e_rdy[0] && hv[0];
    acc_prev[1] = e_rdy[1] && hv[1];
    rsp_hs_prev = rsp_v && e_rsprdy;
    if (rsp_hs_prev) begin
      if (hit) begin
        m_src.delete(int'(resp_id)); m_uid.delete(int'(resp_id));
      end else m_stray = 1'b1;
    end
    if (e_rv && req_ready) begin
      m_src[tag] = sel; m_uid[tag] = hid[sel]; m_last = sel; m_pend = 1'b0;
    end else begin
      m_pend = e_rv; m_pend_src = sel; m_pend_tag = tag;
    end
  endtask

  initial begin
    vecs[0]  = '{1,1,1,0,2'd0,1,1, 1,2'd0,1,0,3'd0, 1,0,0,2'd0};
    vecs[1]  = '{1,1,1,0,2'd0,1,1, 1,2'd1,0,1,3'd1, 1,0,0,2'd0};
    vecs[2]  = '{1,1,1,0,2'd0,1,1, 1,2'd2,1,0,3'd2, 1,0,0,2'd0};
    vecs[3]  = '{1,1,1,0,2'd0,1,1, 1,2'd3,0,1,3'd3, 1,0,0,2'd0};
    vecs[4]  = '{1,1,1,1,2'd2,1,1, 0,2'd0,0,0,3'd4, 1,1,0,2'd2};
    vecs[5]  = '{1,1,1,1,2'd1,1,0, 1,2'd2,1,0,3'd3, 0,0,1,2'd1};
    vecs[6]  = '{1,1,1,1,2'd1,1,1, 0,2'd0,0,0,3'd4, 1,0,1,2'd1};
    vecs[7]  = '{1,1,0,0,2'd0,1,1, 1,2'd1,0,0,3'd3, 1,0,0,2'd0};
    vecs[8]  = '{1,1,1,1,2'd0,1,1, 1,2'd1,0,1,3'd3, 1,1,0,2'd2};
    vecs[9]  = '{1,1,1,0,2'd0,1,1, 1,2'd0,1,0,3'd3, 1,0,0,2'd0};
    vecs[10] = '{0,0,1,1,2'd3,1,1, 0,2'd0,0,0,3'd4, 1,0,1,2'd1};
    vecs[11] = '{0,0,1,0,2'd0,1,1, 0,2'd0,1,0,3'd3, 1,0,0,2'd0};

    // reset: all handshake outputs forced low even with live inputs
    idle_inputs();
    rst = 1'b1;
    r0_req_valid = 1'b1; resp_valid = 1'b1;
    @(negedge clk);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_r0_req_ready", r0_req_ready, 1'b0);
    chk("rst_resp_ready", resp_ready, 1'b0);
    chk("rst_r0_resp_valid", r0_resp_valid, 1'b0);
    chk("rst_outstanding", outstanding, 3'd0);
    @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      r0_req_valid = vecs[i].r0v; r1_req_valid = vecs[i].r1v;
      req_ready = vecs[i].rdy; resp_valid = vecs[i].rspv; resp_id = vecs[i].rspid;
      r0_resp_ready = vecs[i].r0rr; r1_resp_ready = vecs[i].r1rr;
      @(negedge clk);
      if (i == 0) chk("vec_stray_after_reset", stray_resp, 1'b0);
      chk($sformatf("vec%0d_req_valid", i), req_valid, vecs[i].e_rv);
      if (vecs[i].e_rv) chk($sformatf("vec%0d_req_id", i), req_id, vecs[i].e_rid);
      chk($sformatf("vec%0d_r0_req_ready", i), r0_req_ready, vecs[i].e_r0rdy);
      chk($sformatf("vec%0d_r1_req_ready", i), r1_req_ready, vecs[i].e_r1rdy);
      chk($sformatf("vec%0d_outstanding", i), outstanding, vecs[i].e_out);
      chk($sformatf("vec%0d_resp_ready", i), resp_ready, vecs[i].e_rsprdy);
      chk($sformatf("vec%0d_r0_resp_valid", i), r0_resp_valid, vecs[i].e_r0rspv);
      chk($sformatf("vec%0d_r1_resp_valid", i), r1_resp_valid, vecs[i].e_r1rspv);
      if (vecs[i].e_r0rspv) chk($sformatf("vec%0d_r0_resp_id", i), r0_resp_id, vecs[i].e_uid);
      if (vecs[i].e_r1rspv) chk($sformatf("vec%0d_r1_resp_id", i), r1_resp_id, vecs[i].e_uid);
    end

    // tags 0,1,2 now held; stray response on free tag 3
    @(posedge clk); #1;
    idle_inputs(); resp_valid = 1'b1; resp_id = 2'd3;
    @(negedge clk);
    chk("stray_resp_ready", resp_ready, 1'b1);
    chk("stray_r0_resp_valid", r0_resp_valid, 1'b0);
    chk("stray_r1_resp_valid", r1_resp_valid, 1'b0);
    chk("stray_before_edge", stray_resp, 1'b0);
    // owner backpressure on tag 2 (r0) for two cycles
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      resp_valid = 1'b1; resp_id = 2'd2; r0_resp_ready = 1'b0;
      @(negedge clk);
      chk("bp_resp_ready", resp_ready, 1'b0);
      chk("bp_r0_resp_valid", r0_resp_valid, 1'b1);
      chk("bp_outstanding", outstanding, 3'd3);
      chk("bp_stray_sticky", stray_resp, 1'b1);
    end
    @(posedge clk); #1;
    r0_resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", resp_ready, 1'b1);
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    chk("bp_freed_outstanding", outstanding, 3'd2);
    // reset with two tags outstanding, then a late response to one of them is stray
    @(posedge clk); #1;
    rst = 1'b1; r0_req_valid = 1'b1;
    @(negedge clk);
    chk("midrst_req_valid", req_valid, 1'b0);
    chk("midrst_outstanding", outstanding, 3'd0);
    @(posedge clk); #1;
    rst = 1'b0; r0_req_valid = 1'b0; resp_valid = 1'b1; resp_id = 2'd0;
    @(negedge clk);
    chk("postrst_outstanding", outstanding, 3'd0);
    chk("postrst_stray_clear", stray_resp, 1'b0);
    chk("postrst_resp_ready", resp_ready, 1'b1);
    chk("postrst_r0_resp_valid", r0_resp_valid, 1'b0);
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    chk("postrst_stray_set", stray_resp, 1'b1);

    // randomized traffic against the reference model
    @(posedge clk); #1;
    idle_inputs(); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3000; k++) step_rand();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
